if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of instruction_memory.
- Holds the program counter and drives the memory's address input.
- Captures the returned instruction, with its PC and PC+4, into the IF/ID pipeline register for decode.
- Handles boot, stall, flush, taken-branch redirect and a retired-fetch counter.

---
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, memory address and IF/ID register.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect halts with a sticky flag.
module if_fetch_stage #(
    parameter int                  BITWIDTH  = 32,
    parameter logic [BITWIDTH-1:0] RESET_PC  = '0,
    parameter logic [BITWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [BITWIDTH-1:0] branch_target,
    output logic [BITWIDTH-1:0] imem_addr,
    input  logic [BITWIDTH-1:0] imem_instr,
    output logic [BITWIDTH-1:0] if_id_pc,
    output logic [BITWIDTH-1:0] if_id_instr,
    output logic [BITWIDTH-1:0] if_id_pc_plus_4,
    output logic                if_id_valid,
    output logic [31:0]         fetch_count,
    output logic                misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t              state, state_n;
    logic [BITWIDTH-1:0] pc, pc_n, pc_plus_4;
    logic [BITWIDTH-1:0] id_pc_n, id_instr_n, id_pc4_n;
    logic                id_valid_n;
    logic [31:0]         count_n;
    logic [BITWIDTH-1:0] redirect;
    logic                misaligned;
    logic                mis_q, mis_n;

    assign imem_addr = pc;
    assign pc_plus_4 = pc + BITWIDTH'(4);

`ifdef IF_ALIGN_CHECK_EN
    assign redirect     = branch_target;
    assign misaligned   = |branch_target[1:0];
    assign misalign_err = mis_q;
`else
    // Low bits are dropped so a redirect always lands on a word.
    assign redirect     = {branch_target[BITWIDTH-1:2], 2'b00};
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_pc_n    = if_id_pc;
        id_instr_n = if_id_instr;
        id_pc4_n   = if_id_pc_plus_4;
        id_valid_n = if_id_valid;
        count_n    = fetch_count;
        mis_n      = mis_q;
        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (branch_taken) begin
                    id_valid_n = 1'b0;
                    id_instr_n = NOP_INSTR;
                    if (misaligned) begin
                        mis_n   = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n = redirect;
                    end
                end else if (stall && flush) begin
                    id_valid_n = 1'b0;
                    id_instr_n = NOP_INSTR;
                end else if (stall) begin
                    pc_n = pc;
                end else if (flush) begin
                    id_valid_n = 1'b0;
                    id_instr_n = NOP_INSTR;
                    pc_n       = pc_plus_4;
                end else begin
                    id_pc_n    = pc;
                    id_instr_n = imem_instr;
                    id_pc4_n   = pc_plus_4;
                    id_valid_n = 1'b1;
                    pc_n       = pc_plus_4;
                    count_n    = fetch_count + 32'd1;
                end
            end
            HALT: begin
                id_valid_n = 1'b0;
                id_instr_n = NOP_INSTR;
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= BOOT;
            pc              <= RESET_PC;
            if_id_pc        <= '0;
            if_id_instr     <= NOP_INSTR;
            if_id_pc_plus_4 <= '0;
            if_id_valid     <= 1'b0;
            fetch_count     <= '0;
            mis_q           <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            if_id_pc        <= id_pc_n;
            if_id_instr     <= id_instr_n;
            if_id_pc_plus_4 <= id_pc4_n;
            if_id_valid     <= id_valid_n;
            fetch_count     <= count_n;
            mis_q           <= mis_n;
        end
    end

`ifndef IF_ALIGN_CHECK_EN
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a per-cycle reference model.
// Build with IF_ALIGN_CHECK_EN defined to exercise the halt path.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus_4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_instr = mem(imem_addr);

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_valid     (if_id_valid),
        .fetch_count     (fetch_count),
        .misalign_err    (misalign_err)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: 0 = booting, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_ipc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_mis;
    bit          align_chk;

    initial begin
        align_chk = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        align_chk = 1'b1;
`endif
    end

    task automatic bubble();
        m_valid = 1'b0;
        m_instr = 32'h0000_0013;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pc = 0; m_ipc = 0; m_pc4 = 0;
            m_instr = 32'h13; m_valid = 0; m_cnt = 0; m_mis = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            bubble();
        end else if (branch_taken) begin
            bubble();
            if (align_chk && branch_target % 4 != 0) begin
                m_mis = 1'b1;
                m_mode = 2;
            end else begin
                m_pc = branch_target - branch_target % 4;
            end
        end else if (stall && flush) begin
            bubble();
        end else if (stall) begin
        end else if (flush) begin
            bubble();
            m_pc = m_pc + 4;
        end else begin
            m_ipc = m_pc;
            m_instr = mem(m_pc);
            m_pc4 = m_pc + 4;
            m_valid = 1'b1;
            m_pc = m_pc + 4;
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("addr", imem_addr, m_pc);
            chk("instr", if_id_instr, m_instr);
            chk("valid", 32'(if_id_valid), 32'(m_valid));
            chk("count", fetch_count, m_cnt);
            chk("mis", 32'(misalign_err), 32'(m_mis));
            if (m_valid) begin
                chk("pc", if_id_pc, m_ipc);
                chk("pc4", if_id_pc_plus_4, m_pc4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string n, input logic [31:0] a,
                       input logic v, input logic [31:0] c);
        chk({n, "_addr"}, imem_addr, a);
        chk({n, "_valid"}, 32'(if_id_valid), 32'(v));
        chk({n, "_count"}, fetch_count, c);
    endtask

    task automatic br(input logic [31:0] t, input logic s);
        branch_taken = 1'b1;
        branch_target = t;
        stall = s;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        lit("rst", 32'h0, 1'b0, 0);
        chk("rst_instr", if_id_instr, 32'h13);
        tick();
        lit("boot", 32'h0, 1'b0, 0);
        tick();
        lit("first", 32'h4, 1'b1, 1);
        chk("first_instr", if_id_instr, 32'h1000_0000);
        chk("first_pc", if_id_pc, 32'h0);
        chk("first_pc4", if_id_pc_plus_4, 32'h4);
        tick();
        lit("run", 32'h8, 1'b1, 2);

        stall = 1'b1;
        repeat (3) tick();
        lit("stall", 32'h8, 1'b1, 2);
        chk("stall_instr", if_id_instr, 32'h1000_0001);
        stall = 1'b0;
        tick();
        lit("unstall", 32'hC, 1'b1, 3);
        chk("unstall_pc", if_id_pc, 32'h8);

        br(32'h40, 1'b1);
        lit("br", 32'h40, 1'b0, 3);
        chk("br_instr", if_id_instr, 32'h13);
        tick();
        lit("br_next", 32'h44, 1'b1, 4);
        chk("br_pc", if_id_pc, 32'h40);
        chk("br_ins2", if_id_instr, 32'h1000_0010);

        br(32'h10, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        lit("flush", 32'h14, 1'b0, 4);
        br(32'h10, 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        lit("sflush", 32'h10, 1'b0, 4);
        tick();
        lit("sf_next", 32'h14, 1'b1, 5);
        chk("sf_pc", if_id_pc, 32'h10);

        br(32'hFFFF_FFFC, 1'b0);
        lit("wrap_br", 32'hFFFF_FFFC, 1'b0, 5);
        tick();
        lit("wrap", 32'h0, 1'b1, 6);
        chk("wrap_pc4", if_id_pc_plus_4, 32'h0);
        chk("wrap_ins", if_id_instr, 32'h4FFF_FFFF);
        tick();
        lit("wrap2", 32'h4, 1'b1, 7);

        br(32'h42, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
        lit("halt", 32'h4, 1'b0, 7);
        chk("halt_mis", 32'(misalign_err), 32'h1);
        repeat (2) tick();
        lit("halt2", 32'h4, 1'b0, 7);
`else
        lit("mask", 32'h40, 1'b0, 7);
        chk("mask_mis", 32'(misalign_err), 32'h0);
        tick();
        lit("mask2", 32'h44, 1'b1, 8);
`endif

        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        lit("mid_rst", 32'h0, 1'b0, 0);
        chk("mid_instr", if_id_instr, 32'h13);
        chk("mid_pc", if_id_pc, 32'h0);
        chk("mid_pc4", if_id_pc_plus_4, 32'h0);
        chk("mid_mis", 32'(misalign_err), 32'h0);
        #2 reset = 1'b0;
        tick();
        lit("reboot", 32'h0, 1'b0, 0);
        tick();
        lit("rerun", 32'h4, 1'b1, 1);
        chk("rerun_pc", if_id_pc, 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
